// File: rtl/kgp_mc_controller.sv
// Multi-cycle controller: sequences fetch/decode/exec/mem/writeback and decodes
// datapath controls from the current state plus the instruction fields.
module kgp_mc_controller #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [4:0]  funccode,
    input  logic        zeroFlag,
    input  logic        negFlag,
    input  logic        carryFlag,
    input  logic        mem_ready,
    output logic        pcWrite,
    output logic        irWrite,
    output logic        regWrite,
    output logic        memRead,
    output logic        memWrite,
    output logic        memToReg,
    output logic        brLink,
    output logic        branch,
    output logic        ALUFrc,
    output logic [1:0]  ALUSrc,
    output logic [3:0]  ALUResOp,
    output logic        halted,
    output logic        err,
    output logic [31:0] instrCount
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [5:0] OP_RALU = 6'b000000;
    localparam logic [5:0] OP_IALU = 6'b000001;
    localparam logic [5:0] OP_LW   = 6'b000010;
    localparam logic [5:0] OP_SW   = 6'b000011;
    localparam logic [5:0] OP_B    = 6'b000100;
    localparam logic [5:0] OP_BL   = 6'b000101;
    localparam logic [5:0] OP_BR   = 6'b000110;
    localparam logic [5:0] OP_BCND = 6'b000111;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WW-1:0]   r_wait;
    logic [31:0]     r_instr_cnt;

    logic            w_legal;
    logic            w_is_lw;
    logic            w_is_sw;
    logic            w_is_bl;
    logic            w_timeout;
    logic            w_cond_ok;
    logic            w_cond_taken;
    logic            w_retire;
    logic            w_mem_state;

    assign w_is_lw     = (opcode == OP_LW);
    assign w_is_sw     = (opcode == OP_SW);
    assign w_is_bl     = (opcode == OP_BL);
    assign w_legal     = (opcode <= OP_BCND) || (opcode == OP_HALT);
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM);
    // This is the MEM_TIMEOUT-th consecutive cycle without mem_ready.
    assign w_timeout   = !mem_ready && (r_wait == WW'(MEM_TIMEOUT - 1));

    always_comb begin
        w_cond_ok    = 1'b1;
        w_cond_taken = 1'b0;
        case (funccode)
            5'b00000: w_cond_taken = negFlag;
            5'b00001: w_cond_taken = zeroFlag;
            5'b00010: w_cond_taken = !zeroFlag;
            5'b00011: w_cond_taken = carryFlag;
            5'b00100: w_cond_taken = !carryFlag;
            default:  w_cond_ok    = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        pcWrite  = 1'b0;
        irWrite  = 1'b0;
        regWrite = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        memToReg = 1'b0;
        brLink   = 1'b0;
        branch   = 1'b0;
        ALUFrc   = 1'b0;
        ALUSrc   = 2'd0;
        ALUResOp = 4'd0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                memRead = 1'b1;
                if (mem_ready) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DECODE: begin
                if (!w_legal)                w_next = S_ERR;
                else if (opcode == OP_HALT)  w_next = S_HALT;
                else                         w_next = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_RALU: begin
                        ALUFrc   = 1'b1;
                        ALUSrc   = funccode[4] ? 2'd2 : 2'd0;
                        ALUResOp = funccode[3:0];
                        w_next   = S_WB;
                    end
                    OP_IALU: begin
                        ALUFrc   = 1'b1;
                        ALUSrc   = 2'd1;
                        ALUResOp = funccode[3:0];
                        w_next   = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        ALUSrc = 2'd1;
                        w_next = S_MEM;
                    end
                    OP_B, OP_BR: begin
                        branch  = 1'b1;
                        pcWrite = 1'b1;
                        w_next  = S_FETCH;
                    end
                    OP_BL: begin
                        branch  = 1'b1;
                        pcWrite = 1'b1;
                        w_next  = S_WB;
                    end
                    OP_BCND: begin
                        if (w_cond_ok) begin
                            branch  = w_cond_taken;
                            pcWrite = w_cond_taken;
                            w_next  = S_FETCH;
                        end else begin
                            w_next = S_ERR;
                        end
                    end
                    default: w_next = S_ERR;
                endcase
            end
            S_MEM: begin
                if (w_is_lw || w_is_sw) begin
                    memRead  = w_is_lw;
                    memWrite = w_is_sw;
                    if (mem_ready)      w_next = w_is_lw ? S_WB : S_FETCH;
                    else if (w_timeout) w_next = S_ERR;
                end else begin
                    w_next = S_ERR;
                end
            end
            S_WB: begin
                regWrite = 1'b1;
                memToReg = w_is_lw;
                brLink   = w_is_bl;
                w_next   = S_FETCH;
            end
            default: w_next = r_state;
        endcase
    end

    // An instruction retires when control returns to FETCH or enters HALT.
    assign w_retire = (((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB))
                       && (w_next == S_FETCH))
                   || ((r_state == S_DECODE) && (w_next == S_HALT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_cnt <= 32'd0;
        end else if (w_retire) begin
            r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else if (w_mem_state && !mem_ready && (w_next == r_state)) begin
            r_wait <= r_wait + 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    assign halted     = (r_state == S_HALT);
    assign err        = (r_state == S_ERR);
    assign instrCount = r_instr_cnt;

endmodule

// File: tb/tb_kgp_mc_controller.sv
module tb_kgp_mc_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [4:0]  funccode = 5'd0;
    logic        zeroFlag = 1'b0;
    logic        negFlag = 1'b0;
    logic        carryFlag = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pcWrite, irWrite, regWrite, memRead, memWrite, memToReg;
    logic        brLink, branch, ALUFrc, halted, err;
    logic [1:0]  ALUSrc;
    logic [3:0]  ALUResOp;
    logic [31:0] instrCount;

    kgp_mc_controller #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funccode(funccode),
        .zeroFlag(zeroFlag), .negFlag(negFlag), .carryFlag(carryFlag),
        .mem_ready(mem_ready), .pcWrite(pcWrite), .irWrite(irWrite),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
        .memToReg(memToReg), .brLink(brLink), .branch(branch), .ALUFrc(ALUFrc),
        .ALUSrc(ALUSrc), .ALUResOp(ALUResOp), .halted(halted), .err(err),
        .instrCount(instrCount)
    );

    always #5 clk = ~clk;

    localparam logic [16:0] C_N  = 17'h00000;
    localparam logic [16:0] C_RD = 17'h02000;
    localparam logic [16:0] C_WR = 17'h01000;
    localparam logic [16:0] C_FD = 17'h1A000;
    localparam logic [16:0] C_WB = 17'h04000;
    localparam logic [16:0] C_BR = 17'h10200;
    localparam logic [16:0] C_H  = 17'h00002;
    localparam logic [16:0] C_E  = 17'h00001;

    function automatic logic [16:0] exec_cw(input logic af, input logic [1:0] src,
                                            input logic [3:0] op);
        return {9'b0, af, src, op, 2'b0};
    endfunction

    logic [16:0] q_cw[$];
    logic [31:0] q_cnt[$];
    string       q_tag[$];
    logic [31:0] exp_cnt = 32'd0;
    int          checks = 0;
    int          errors = 0;

    wire [16:0] act_cw = {pcWrite, irWrite, regWrite, memRead, memWrite, memToReg,
                          brLink, branch, ALUFrc, ALUSrc, ALUResOp, halted, err};

    always @(negedge clk) begin
        if (q_cw.size() > 0) begin
            logic [16:0] e_cw;
            logic [31:0] e_cnt;
            string       tag;
            e_cw  = q_cw.pop_front();
            e_cnt = q_cnt.pop_front();
            tag   = q_tag.pop_front();
            checks++;
            if (act_cw !== e_cw || instrCount !== e_cnt) begin
                errors++;
                $display("FAIL %s: ctrl got %05h want %05h, instrCount got %0d want %0d",
                         tag, act_cw, e_cw, instrCount, e_cnt);
            end
        end
    end

    task automatic step(input logic r, input logic mr, input logic [16:0] c,
                        input string tag);
        run       = r;
        mem_ready = mr;
        q_cw.push_back(c);
        q_cnt.push_back(exp_cnt);
        q_tag.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int waits);
        for (int i = 0; i < waits; i++) step(1'b0, 1'b0, C_RD, "fetch_wait");
        step(1'b0, 1'b1, C_FD, "fetch");
        step(1'b0, 1'b1, C_N, "decode");
    endtask

    task automatic alu_instr(input logic [5:0] op, input logic [4:0] fc,
                             input logic [16:0] ecw);
        opcode   = op;
        funccode = fc;
        fetch(0);
        step(1'b1, 1'b1, ecw, "exec_alu");
        step(1'b0, 1'b1, C_WB, "wb_alu");
        exp_cnt++;
    endtask

    task automatic br_instr(input logic [5:0] op, input logic [4:0] fc,
                            input logic [16:0] ecw);
        opcode   = op;
        funccode = fc;
        fetch(0);
        step(1'b0, 1'b1, ecw, "exec_br");
        exp_cnt++;
    endtask

    task automatic do_reset(input logic [16:0] cur_cw);
        rst = 1'b1;
        step(1'b0, 1'b0, cur_cw, "rst_edge");
        exp_cnt = 32'd0;
        rst = 1'b0;
        step(1'b0, 1'b1, C_N, "post_rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, C_N, "reset_state");
        rst = 1'b0;
        step(1'b0, 1'b1, C_N, "idle_norun");
        step(1'b1, 1'b0, C_N, "idle_run");

        alu_instr(6'b000000, 5'b00000, exec_cw(1'b1, 2'd0, 4'd0));
        alu_instr(6'b000000, 5'b10011, exec_cw(1'b1, 2'd2, 4'd3));
        alu_instr(6'b000001, 5'b00101, exec_cw(1'b1, 2'd1, 4'd5));

        opcode = 6'b000010;
        fetch(14);
        step(1'b0, 1'b1, exec_cw(1'b0, 2'd1, 4'd0), "exec_lw");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, C_RD, "mem_lw_wait");
        step(1'b0, 1'b1, C_RD, "mem_lw_done");
        step(1'b0, 1'b0, 17'h04800, "wb_lw");
        exp_cnt++;

        opcode = 6'b000011;
        fetch(0);
        step(1'b0, 1'b1, exec_cw(1'b0, 2'd1, 4'd0), "exec_sw");
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, C_WR, "mem_sw_wait");
        step(1'b0, 1'b1, C_WR, "mem_sw_done");
        exp_cnt++;

        zeroFlag = 1'b1;  br_instr(6'b000111, 5'b00001, C_BR);
        zeroFlag = 1'b0;  br_instr(6'b000111, 5'b00001, C_N);
        negFlag  = 1'b1;  br_instr(6'b000111, 5'b00000, C_BR);
        negFlag  = 1'b0;  br_instr(6'b000111, 5'b00010, C_BR);
        carryFlag = 1'b1; br_instr(6'b000111, 5'b00011, C_BR);
        br_instr(6'b000111, 5'b00100, C_N);
        carryFlag = 1'b0;

        opcode = 6'b000101;
        fetch(0);
        step(1'b0, 1'b1, C_BR, "exec_bl");
        step(1'b0, 1'b1, 17'h04400, "wb_bl");
        exp_cnt++;
        br_instr(6'b000100, 5'b00000, C_BR);
        br_instr(6'b000110, 5'b00000, C_BR);

        opcode   = 6'b000111;
        funccode = 5'b00101;
        fetch(0);
        step(1'b0, 1'b1, C_N, "exec_badcond");
        step(1'b1, 1'b1, C_E, "err_sticky0");
        step(1'b0, 1'b0, C_E, "err_sticky1");

        do_reset(C_E);
        opcode = 6'b001000;
        step(1'b1, 1'b0, C_N, "idle_run");
        fetch(0);
        step(1'b1, 1'b1, C_E, "illegal_err0");
        step(1'b0, 1'b1, C_E, "illegal_err1");
        step(1'b1, 1'b0, C_E, "illegal_err2");

        do_reset(C_E);
        step(1'b1, 1'b0, C_N, "idle_run");
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, C_RD, "fetch_stall");
        step(1'b0, 1'b1, C_E, "timeout_err0");
        step(1'b1, 1'b1, C_E, "timeout_err1");
        if (err !== 1'b1 || irWrite !== 1'b0) begin
            errors++;
            $display("FAIL timeout_direct: err=%b irWrite=%b", err, irWrite);
        end

        do_reset(C_E);
        step(1'b1, 1'b0, C_N, "idle_run");
        for (int i = 0; i < 5; i++) br_instr(6'b000100, 5'b00000, C_BR);
        opcode = 6'b111111;
        fetch(0);
        exp_cnt++;
        step(1'b1, 1'b1, C_H, "halt0");
        step(1'b0, 1'b1, C_H, "halt1");
        step(1'b1, 1'b1, C_H, "halt2");
        if (halted !== 1'b1 || instrCount !== 32'd6 || memRead !== 1'b0) begin
            errors++;
            $display("FAIL halt_direct: halted=%b instrCount=%0d memRead=%b",
                     halted, instrCount, memRead);
        end

        do_reset(C_H);
        step(1'b1, 1'b0, C_N, "idle_run");
        alu_instr(6'b000000, 5'b00000, exec_cw(1'b1, 2'd0, 4'd0));
        opcode = 6'b000010;
        fetch(0);
        step(1'b0, 1'b1, exec_cw(1'b0, 2'd1, 4'd0), "exec_lw2");
        step(1'b0, 1'b0, C_RD, "mem_wait0");
        step(1'b0, 1'b0, C_RD, "mem_wait1");
        do_reset(C_RD);
        step(1'b0, 1'b1, C_N, "idle_after_rst");
        if (act_cw !== C_N || instrCount !== 32'd0) begin
            errors++;
            $display("FAIL rst_direct: ctrl=%05h instrCount=%0d", act_cw, instrCount);
        end

        @(negedge clk);
        #1;
        if (q_cw.size() != 0 || checks == 0) begin
            errors++;
            $display("FAIL monitor: %0d pending, %0d checks", q_cw.size(), checks);
        end
        if (errors != 0) $display("FAIL: %0d errors", errors);
        else             $display("PASS");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
